// File: rtl/tank_select.sv
// Tank-number flashing unit: holds the tank address, word position and length/odd flags
// across Stage I (SCT) and Stage II (order), and drives the one-hot tank select and word window.
module tank_select #(
    parameter int ADDR_W       = 5,
    parameter int NUM_TANKS    = 32,
    parameter int POS_W        = 4,
    parameter int MINOR_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mc_tick,
    input  logic                 sct_load,
    input  logic                 ord_load,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [POS_W-1:0]     ld_pos,
    input  logic                 ld_long,
    input  logic                 ld_odd,
    input  logic                 end_stage1,
    input  logic                 epsep,
    output logic [ADDR_W-1:0]    tank_addr,
    output logic [NUM_TANKS-1:0] tank_sel,
    output logic [POS_W-1:0]     word_pos,
    output logic                 long_word,
    output logic                 odd_half,
    output logic [1:0]           stage,
    output logic                 word_window,
    output logic [POS_W-1:0]     mc_cnt,
    output logic                 seq_err,
    output logic                 range_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_ORD = 2'd2,
        ST_EXEC     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                long_q, long_d;
    logic                odd_q, odd_d;
    logic [POS_W-1:0]    mc_cnt_q, mc_cnt_d;
    logic                seq_err_q, seq_err_d;
    logic                range_err_q, range_err_d;

    logic                addr_ok;
    logic                do_load;
    logic                do_clear;
    logic                active;
    logic [POS_W-1:0]    pos_next;

    assign addr_ok = (32'(ld_addr) < 32'(NUM_TANKS));
    assign active  = (state_q == ST_FETCH) || (state_q == ST_EXEC);

    always_comb begin
        state_d     = state_q;
        seq_err_d   = 1'b0;
        range_err_d = 1'b0;
        do_load     = 1'b0;
        do_clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ord_load) seq_err_d = 1'b1;
                if (sct_load) begin
                    if (addr_ok) begin
                        do_load = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (sct_load) seq_err_d = 1'b1;
                if (end_stage1) begin
                    do_clear = 1'b1;
                    state_d  = ST_WAIT_ORD;
                    // An order arriving with the end-of-stage pulse is a legal back-to-back load
                    if (ord_load) begin
                        if (addr_ok) begin
                            do_load = 1'b1;
                            state_d = ST_EXEC;
                        end else begin
                            range_err_d = 1'b1;
                        end
                    end
                end else if (ord_load) begin
                    seq_err_d = 1'b1;
                end
            end
            ST_WAIT_ORD: begin
                if (sct_load) seq_err_d = 1'b1;
                if (ord_load) begin
                    if (addr_ok) begin
                        do_load = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (ord_load) seq_err_d = 1'b1;
                if (epsep) begin
                    do_clear = 1'b1;
                    state_d  = ST_IDLE;
                    if (sct_load) begin
                        if (addr_ok) begin
                            do_load = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            range_err_d = 1'b1;
                        end
                    end
                end else if (sct_load) begin
                    seq_err_d = 1'b1;
                end
            end
        endcase
    end

    // Load takes priority over the clear when both act in the same cycle
    always_comb begin
        addr_d = addr_q;
        pos_d  = pos_q;
        long_d = long_q;
        odd_d  = odd_q;
        if (do_clear) begin
            addr_d = '0;
            pos_d  = '0;
            long_d = 1'b0;
            odd_d  = 1'b0;
        end
        if (do_load) begin
            addr_d = ld_addr;
            pos_d  = ld_pos;
            long_d = ld_long;
            odd_d  = ld_odd;
        end
    end

    always_comb begin
        mc_cnt_d = mc_cnt_q;
        if (mc_tick) begin
            if (32'(mc_cnt_q) >= 32'(MINOR_CYCLES - 1)) mc_cnt_d = '0;
            else                                       mc_cnt_d = mc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            pos_q       <= '0;
            long_q      <= 1'b0;
            odd_q       <= 1'b0;
            mc_cnt_q    <= '0;
            seq_err_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pos_q       <= pos_d;
            long_q      <= long_d;
            odd_q       <= odd_d;
            mc_cnt_q    <= mc_cnt_d;
            seq_err_q   <= seq_err_d;
            range_err_q <= range_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TANKS; gi++) begin : g_sel
            assign tank_sel[gi] = active && (addr_q == ADDR_W'(gi));
        end
    endgenerate

    // A long word occupies two consecutive minor cycles, wrapping at the major-cycle boundary
    assign pos_next    = POS_W'((32'(pos_q) + 32'd1) % 32'(MINOR_CYCLES));
    assign word_window = active && ((mc_cnt_q == pos_q) || (long_q && (mc_cnt_q == pos_next)));

    assign tank_addr = addr_q;
    assign word_pos  = pos_q;
    assign long_word = long_q;
    assign odd_half  = odd_q;
    assign stage     = state_q;
    assign mc_cnt    = mc_cnt_q;
    assign seq_err   = seq_err_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_tank_select.sv
// Directed bench for tank_select: a 32-tank instance for the main flow and a 20-tank
// instance sharing the same stimulus for the address range checks.
module tb_tank_select;

    logic        clk;
    logic        rst_n;
    logic        mc_tick;
    logic        sct_load;
    logic        ord_load;
    logic [4:0]  ld_addr;
    logic [3:0]  ld_pos;
    logic        ld_long;
    logic        ld_odd;
    logic        end_stage1;
    logic        epsep;

    logic [4:0]  tank_addr;
    logic [31:0] tank_sel;
    logic [3:0]  word_pos;
    logic        long_word;
    logic        odd_half;
    logic [1:0]  stage;
    logic        word_window;
    logic [3:0]  mc_cnt;
    logic        seq_err;
    logic        range_err;

    logic [4:0]  r_tank_addr;
    logic [19:0] r_tank_sel;
    logic [3:0]  r_word_pos;
    logic        r_long_word;
    logic        r_odd_half;
    logic [1:0]  r_stage;
    logic        r_word_window;
    logic [3:0]  r_mc_cnt;
    logic        r_seq_err;
    logic        r_range_err;

    int total;
    int bad;

    tank_select #(.ADDR_W(5), .NUM_TANKS(32), .POS_W(4), .MINOR_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .mc_tick(mc_tick), .sct_load(sct_load), .ord_load(ord_load),
        .ld_addr(ld_addr), .ld_pos(ld_pos), .ld_long(ld_long), .ld_odd(ld_odd),
        .end_stage1(end_stage1), .epsep(epsep),
        .tank_addr(tank_addr), .tank_sel(tank_sel), .word_pos(word_pos), .long_word(long_word),
        .odd_half(odd_half), .stage(stage), .word_window(word_window), .mc_cnt(mc_cnt),
        .seq_err(seq_err), .range_err(range_err)
    );

    tank_select #(.ADDR_W(5), .NUM_TANKS(20), .POS_W(4), .MINOR_CYCLES(16)) dut20 (
        .clk(clk), .rst_n(rst_n), .mc_tick(mc_tick), .sct_load(sct_load), .ord_load(ord_load),
        .ld_addr(ld_addr), .ld_pos(ld_pos), .ld_long(ld_long), .ld_odd(ld_odd),
        .end_stage1(end_stage1), .epsep(epsep),
        .tank_addr(r_tank_addr), .tank_sel(r_tank_sel), .word_pos(r_word_pos),
        .long_word(r_long_word), .odd_half(r_odd_half), .stage(r_stage),
        .word_window(r_word_window), .mc_cnt(r_mc_cnt),
        .seq_err(r_seq_err), .range_err(r_range_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mc_tick = 0; sct_load = 0; ord_load = 0; end_stage1 = 0; epsep = 0;
        ld_addr = '0; ld_pos = '0; ld_long = 0; ld_odd = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic sct(input logic [4:0] a, input logic [3:0] p, input logic lg, input logic od);
        sct_load = 1; ld_addr = a; ld_pos = p; ld_long = lg; ld_odd = od;
        tick();
        sct_load = 0;
    endtask

    task automatic ord(input logic [4:0] a, input logic [3:0] p, input logic lg, input logic od);
        ord_load = 1; ld_addr = a; ld_pos = p; ld_long = lg; ld_odd = od;
        tick();
        ord_load = 0;
    endtask

    task automatic end1();
        end_stage1 = 1;
        tick();
        end_stage1 = 0;
    endtask

    task automatic mc_step();
        mc_tick = 1;
        tick();
        mc_tick = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        total++; if (stage !== 2'd0) begin bad++; $display("FAIL reset_stage: got=%0d want=0", stage); end
        total++; if (tank_sel !== 32'h0) begin bad++; $display("FAIL reset_tank_sel: got=%h want=0", tank_sel); end
        total++; if (tank_addr !== 5'd0) begin bad++; $display("FAIL reset_tank_addr: got=%0d want=0", tank_addr); end
        total++; if (mc_cnt !== 4'd0) begin bad++; $display("FAIL reset_mc_cnt: got=%0d want=0", mc_cnt); end
        total++; if ({word_window, seq_err, range_err, long_word, odd_half} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got=%b want=00000", {word_window, seq_err, range_err, long_word, odd_half});
        end
        $display("test_reset: stage=%0d tank_sel=%h mc_cnt=%0d", stage, tank_sel, mc_cnt);
    endtask

    task automatic test_fetch_window();
        reset_dut();
        sct(5'd5, 4'd3, 1'b0, 1'b1);
        total++; if (stage !== 2'd1) begin bad++; $display("FAIL fetch_stage: got=%0d want=1", stage); end
        total++; if (tank_sel !== 32'h20) begin bad++; $display("FAIL fetch_tank_sel: got=%h want=00000020", tank_sel); end
        total++; if (tank_addr !== 5'd5) begin bad++; $display("FAIL fetch_tank_addr: got=%0d want=5", tank_addr); end
        total++; if (word_pos !== 4'd3 || odd_half !== 1'b1) begin
            bad++; $display("FAIL fetch_pos_odd: got pos=%0d odd=%b want pos=3 odd=1", word_pos, odd_half);
        end
        for (int i = 0; i < 16; i++) begin
            total++; if (mc_cnt !== 4'(i)) begin bad++; $display("FAIL fetch_mc_cnt: got=%0d want=%0d", mc_cnt, i); end
            total++; if (word_window !== (i == 3)) begin
                bad++; $display("FAIL fetch_window: mc_cnt=%0d got=%b want=%b", i, word_window, (i == 3));
            end
            mc_step();
        end
        total++; if (mc_cnt !== 4'd0) begin bad++; $display("FAIL fetch_mc_wrap: got=%0d want=0", mc_cnt); end
        $display("test_fetch_window: stage=%0d tank_addr=%0d", stage, tank_addr);
    endtask

    task automatic test_full_sequence();
        reset_dut();
        sct(5'd7, 4'd0, 1'b0, 1'b0);
        total++; if (stage !== 2'd1) begin bad++; $display("FAIL seq_stage1: got=%0d want=1", stage); end
        end1();
        total++; if (stage !== 2'd2) begin bad++; $display("FAIL seq_stage2: got=%0d want=2", stage); end
        total++; if (tank_sel !== 32'h0 || tank_addr !== 5'd0) begin
            bad++; $display("FAIL seq_clear1: got sel=%h addr=%0d want sel=0 addr=0", tank_sel, tank_addr);
        end
        ord(5'd31, 4'd15, 1'b1, 1'b0);
        total++; if (stage !== 2'd3) begin bad++; $display("FAIL seq_stage3: got=%0d want=3", stage); end
        total++; if (tank_sel !== 32'h8000_0000) begin bad++; $display("FAIL seq_tank_sel: got=%h want=80000000", tank_sel); end
        total++; if (long_word !== 1'b1 || word_pos !== 4'd15) begin
            bad++; $display("FAIL seq_long: got long=%b pos=%0d want long=1 pos=15", long_word, word_pos);
        end
        for (int i = 0; i < 16; i++) begin
            total++; if (word_window !== (i == 15 || i == 0)) begin
                bad++; $display("FAIL seq_window: mc_cnt=%0d got=%b want=%b", i, word_window, (i == 15 || i == 0));
            end
            mc_step();
        end
        epsep = 1;
        tick();
        epsep = 0;
        total++; if (stage !== 2'd0) begin bad++; $display("FAIL seq_stage0: got=%0d want=0", stage); end
        total++; if (tank_sel !== 32'h0 || word_window !== 1'b0) begin
            bad++; $display("FAIL seq_clear2: got sel=%h win=%b want sel=0 win=0", tank_sel, word_window);
        end
        $display("test_full_sequence: stage=%0d tank_sel=%h", stage, tank_sel);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        sct(5'd1, 4'd0, 1'b0, 1'b0);
        end1();
        ord(5'd4, 4'd6, 1'b0, 1'b0);
        epsep = 1; sct_load = 1; ld_addr = 5'd2; ld_pos = 4'd9; ld_long = 0; ld_odd = 0;
        tick();
        epsep = 0; sct_load = 0;
        total++; if (stage !== 2'd1) begin bad++; $display("FAIL b2b_exec_stage: got=%0d want=1", stage); end
        total++; if (tank_addr !== 5'd2 || tank_sel !== 32'h4 || word_pos !== 4'd9) begin
            bad++; $display("FAIL b2b_exec_regs: got addr=%0d sel=%h pos=%0d want addr=2 sel=4 pos=9", tank_addr, tank_sel, word_pos);
        end
        total++; if (seq_err !== 1'b0 || range_err !== 1'b0) begin
            bad++; $display("FAIL b2b_exec_err: got seq=%b range=%b want 0 0", seq_err, range_err);
        end
        end_stage1 = 1; ord_load = 1; ld_addr = 5'd9; ld_pos = 4'd1; ld_long = 1; ld_odd = 1;
        tick();
        end_stage1 = 0; ord_load = 0;
        total++; if (stage !== 2'd3) begin bad++; $display("FAIL b2b_fetch_stage: got=%0d want=3", stage); end
        total++; if (tank_addr !== 5'd9 || tank_sel !== 32'h200 || long_word !== 1'b1 || odd_half !== 1'b1) begin
            bad++; $display("FAIL b2b_fetch_regs: got addr=%0d sel=%h long=%b odd=%b want 9 200 1 1", tank_addr, tank_sel, long_word, odd_half);
        end
        total++; if (seq_err !== 1'b0 || range_err !== 1'b0) begin
            bad++; $display("FAIL b2b_fetch_err: got seq=%b range=%b want 0 0", seq_err, range_err);
        end
        $display("test_back_to_back: stage=%0d tank_addr=%0d", stage, tank_addr);
    endtask

    task automatic test_range();
        reset_dut();
        sct(5'd25, 4'd0, 1'b0, 1'b0);
        total++; if (r_stage !== 2'd0 || r_range_err !== 1'b1) begin
            bad++; $display("FAIL range_idle: got stage=%0d range_err=%b want 0 1", r_stage, r_range_err);
        end
        tick();
        total++; if (r_range_err !== 1'b0) begin bad++; $display("FAIL range_pulse_len: got=%b want=0", r_range_err); end
        sct(5'd20, 4'd0, 1'b0, 1'b0);
        total++; if (r_stage !== 2'd0 || r_range_err !== 1'b1) begin
            bad++; $display("FAIL range_edge20: got stage=%0d range_err=%b want 0 1", r_stage, r_range_err);
        end
        sct(5'd19, 4'd0, 1'b0, 1'b0);
        total++; if (r_stage !== 2'd1 || r_tank_sel !== 20'h80000 || r_range_err !== 1'b0) begin
            bad++; $display("FAIL range_edge19: got stage=%0d sel=%h err=%b want 1 80000 0", r_stage, r_tank_sel, r_range_err);
        end
        end1();
        ord(5'd4, 4'd0, 1'b0, 1'b0);
        total++; if (r_stage !== 2'd3) begin bad++; $display("FAIL range_exec: got=%0d want=3", r_stage); end
        epsep = 1; sct_load = 1; ld_addr = 5'd25;
        tick();
        epsep = 0; sct_load = 0;
        total++; if (r_stage !== 2'd0 || r_range_err !== 1'b1 || r_tank_sel !== 20'h0 || r_tank_addr !== 5'd0) begin
            bad++; $display("FAIL range_b2b: got stage=%0d err=%b sel=%h addr=%0d want 0 1 0 0", r_stage, r_range_err, r_tank_sel, r_tank_addr);
        end
        $display("test_range: stage=%0d range_err=%b", r_stage, r_range_err);
    endtask

    task automatic test_seq_err();
        reset_dut();
        end_stage1 = 1; epsep = 1;
        tick();
        end_stage1 = 0; epsep = 0;
        total++; if (stage !== 2'd0 || seq_err !== 1'b0) begin
            bad++; $display("FAIL seq_spurious: got stage=%0d seq_err=%b want 0 0", stage, seq_err);
        end
        ord(5'd6, 4'd0, 1'b0, 1'b0);
        total++; if (seq_err !== 1'b1 || stage !== 2'd0 || tank_addr !== 5'd0) begin
            bad++; $display("FAIL seq_ord_idle: got err=%b stage=%0d addr=%0d want 1 0 0", seq_err, stage, tank_addr);
        end
        tick();
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL seq_pulse_len: got=%b want=0", seq_err); end
        sct(5'd1, 4'd0, 1'b0, 1'b0);
        end1();
        ord(5'd8, 4'd2, 1'b0, 1'b0);
        sct(5'd3, 4'd7, 1'b1, 1'b1);
        total++; if (seq_err !== 1'b1 || stage !== 2'd3 || tank_addr !== 5'd8 || word_pos !== 4'd2) begin
            bad++; $display("FAIL seq_sct_exec: got err=%b stage=%0d addr=%0d pos=%0d want 1 3 8 2", seq_err, stage, tank_addr, word_pos);
        end
        epsep = 1;
        tick();
        epsep = 0;
        sct(5'd1, 4'd0, 1'b0, 1'b0);
        end1();
        sct_load = 1; ord_load = 1; ld_addr = 5'd10; ld_pos = 4'd5; ld_long = 0; ld_odd = 0;
        tick();
        sct_load = 0; ord_load = 0;
        total++; if (seq_err !== 1'b1 || stage !== 2'd3 || tank_addr !== 5'd10) begin
            bad++; $display("FAIL seq_both_wait: got err=%b stage=%0d addr=%0d want 1 3 10", seq_err, stage, tank_addr);
        end
        epsep = 1;
        tick();
        epsep = 0;
        sct_load = 1; ld_addr = 5'd12;
        tick();
        total++; if (stage !== 2'd1 || seq_err !== 1'b0) begin
            bad++; $display("FAIL seq_held_first: got stage=%0d err=%b want 1 0", stage, seq_err);
        end
        tick();
        sct_load = 0;
        total++; if (stage !== 2'd1 || seq_err !== 1'b1) begin
            bad++; $display("FAIL seq_held_second: got stage=%0d err=%b want 1 1", stage, seq_err);
        end
        $display("test_seq_err: stage=%0d tank_addr=%0d", stage, tank_addr);
    endtask

    task automatic test_async_reset();
        reset_dut();
        for (int i = 0; i < 5; i++) mc_step();
        sct(5'd1, 4'd0, 1'b0, 1'b0);
        end1();
        ord(5'd13, 4'd5, 1'b1, 1'b1);
        total++; if (stage !== 2'd3 || mc_cnt !== 4'd5 || word_window !== 1'b1) begin
            bad++; $display("FAIL arst_pre: got stage=%0d mc=%0d win=%b want 3 5 1", stage, mc_cnt, word_window);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (stage !== 2'd0 || tank_sel !== 32'h0 || tank_addr !== 5'd0 || mc_cnt !== 4'd0
                     || {word_pos, long_word, odd_half, word_window} !== 7'b0) begin
            bad++; $display("FAIL arst_clear: got stage=%0d sel=%h addr=%0d mc=%0d want all 0", stage, tank_sel, tank_addr, mc_cnt);
        end
        tick();
        rst_n = 1'b1;
        mc_step();
        mc_step();
        total++; if (mc_cnt !== 4'd2 || stage !== 2'd0) begin
            bad++; $display("FAIL arst_resume: got mc=%0d stage=%0d want 2 0", mc_cnt, stage);
        end
        $display("test_async_reset: stage=%0d mc_cnt=%0d", stage, mc_cnt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_fetch_window();
        test_full_sequence();
        test_back_to_back();
        test_range();
        test_seq_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tank_select.md
# tank_select

Clocked, parametrised tank-number flashing unit for the control section. It captures the tank address, word position, length and odd/even bits from the SCT in Stage I and from the order in Stage II. It holds them across the stage and drives a one-hot tank select to the store, plus a minor-cycle window flag marking when the addressed word is under the read head. It also sequences the Stage I / Stage II hand-over, accepts back-to-back stages, and rejects out-of-range or out-of-sequence loads.

## Interface
- ADDR_W, 5: tank address width.
- NUM_TANKS, 32: number of tanks; must satisfy 2 ≤ NUM_TANKS ≤ 2^ADDR_W.
- POS_W, 4: word-position width within a tank.
- MINOR_CYCLES, 16: minor cycles per major cycle; must satisfy ≤ 2^POS_W.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- mc_tick  in  1  one-clk pulse per minor cycle.
- sct_load  in  1  Stage I load strobe.
- ord_load  in  1  Stage II load strobe.
- ld_addr  in  ADDR_W  tank address to load.
- ld_pos  in  POS_W  word position to load.
- ld_long  in  1  long-word flag to load.
- ld_odd  in  1  odd-short-word flag to load.
- end_stage1  in  1  end-of-Stage-I pulse.
- epsep  in  1  end-of-Stage-II pulse.
- tank_addr  out  ADDR_W  held tank address.
- tank_sel  out  NUM_TANKS  one-hot tank select; all zero when nothing is held.
- word_pos  out  POS_W  held position.
- long_word  out  1  held length flag.
- odd_half  out  1  held odd/even flag.
- stage  out  2  state: 0 IDLE, 1 FETCH, 2 WAIT_ORD, 3 EXEC.
- word_window  out  1  high while the addressed word is current.
- mc_cnt  out  POS_W  minor-cycle counter.
- seq_err  out  1  one-clk pulse: load rejected because of state.
- range_err  out  1  one-clk pulse: load rejected because ld_addr ≥ NUM_TANKS.

## Operation
- FSM transitions:
  - IDLE: sct_load → FETCH.
  - FETCH: end_stage1 → WAIT_ORD; holding registers cleared.
  - WAIT_ORD: ord_load → EXEC.
  - EXEC: epsep → IDLE; holding registers cleared.
- Accepted load: writes ld_addr, ld_pos, ld_long and ld_odd into the holding registers.
- Load rejection:
  - A load whose strobe does not match the state (ord_load outside WAIT_ORD, sct_load outside IDLE) is rejected.
  - A load with ld_addr ≥ NUM_TANKS is rejected.
  - Rejected loads leave registers and state unchanged, apart from any clear acting in the same cycle.
  - If both strobes are high in one cycle, only the strobe legal for the state is considered. The other pulses seq_err.
- Simultaneous clear and load:
  - FETCH with end_stage1 & ord_load (address in range): go straight to EXEC with the order values.
  - EXEC with epsep & sct_load (address in range): go straight to FETCH with the SCT values.
  - If that load has a bad address: the clear still occurs, and range_err pulses.
- Spurious end pulses: end_stage1 outside FETCH and epsep outside EXEC are ignored, with no error.
- tank_sel is combinational from the registers: bit tank_addr is set when stage is FETCH or EXEC; otherwise all zero.
- mc_cnt:
  - Free-running; increments on mc_tick.
  - Wraps from MINOR_CYCLES-1 to 0.
  - Independent of the FSM.
- word_window = (stage is FETCH or EXEC) & (mc_cnt == word_pos). When long_word = 1 it also covers mc_cnt == word_pos+1, modulo MINOR_CYCLES.
- Reset values: every output and register 0; stage = IDLE; mc_cnt = 0.

## Timing
- All state updates on the rising edge of clk. rst_n acts immediately and asynchronously, including mid-stage, with full clear.
- Load latency: one clock. Outputs reflect the load in the cycle after the strobe.
- Clear latency: one clock. tank_sel is zero in the cycle after end_stage1 or epsep.
- seq_err and range_err are registered and high for exactly one cycle after the offending strobe.
- word_window follows mc_cnt with no extra delay. It is valid in the cycle after the mc_tick that advances the counter.
- Strobes are level-sampled each clock. A strobe held for N cycles counts as N events; the second and later ones normally give seq_err.

## Test plan
- Reset then sct_load, addr 5, pos 3 → next cycle: stage=1, tank_sel=0x20, tank_addr=5; word_window high only while mc_cnt=3.
- Full sequence: FETCH, end_stage1, ord_load addr 31 with long=1 pos 15, then epsep → stage goes 1, 2, 3, 0. word_window is high at mc_cnt 15 and 0 (wrap). tank_sel=0 after epsep.
- Back-to-back: in EXEC, epsep + sct_load addr 2 in the same cycle → next cycle stage=1, tank_addr=2, no error. Same check in FETCH with end_stage1 + ord_load → stage=3.
- Range: NUM_TANKS=20, sct_load addr 25 in IDLE → stage stays 0, range_err one pulse. In EXEC, epsep + sct_load addr 25 → stage=0, range_err pulse.
- Sequence errors: ord_load in IDLE, sct_load in EXEC, both strobes in WAIT_ORD → one seq_err pulse each; registers unchanged except that the ord_load in WAIT_ORD is accepted.
- Async reset: drop rst_n mid-EXEC between clock edges → all outputs 0 immediately. mc_cnt=0 and counting resumes on mc_tick after release.
